ipsl_expd_uart_cmd_apb: RTL

Byte-stream command engine that sits directly upstream of the expansion APB mux in the UART clock domain. It parses binary command frames from the UART receiver and runs one APB read or write per frame on the `uart`-side APB master port. It then returns a status byte, plus read data for reads, to the UART transmitter. It is the only APB master driving the mux's `i_uart_p_*` inputs.

---
 rtl/ipsl_expd_uart_cmd_apb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ipsl_expd_uart_cmd_apb.sv
// UART byte-stream command engine: parses command frames and runs one APB access per frame.
// Optional access timeout is enabled by defining IPSL_EXPD_CMD_TIMEOUT_EN.
module ipsl_expd_uart_cmd_apb #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        i_uart_clk,
    input  logic        i_uart_rst_n,
    input  logic        i_rx_vld,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_vld,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_rdy,
    output logic        o_uart_p_sel,
    output logic [3:0]  o_uart_p_strb,
    output logic [15:0] o_uart_p_addr,
    output logic [31:0] o_uart_p_wdata,
    output logic        o_uart_p_ce,
    output logic        o_uart_p_we,
    input  logic        i_uart_p_rdy,
    input  logic [31:0] i_uart_p_rdata,
    output logic        o_busy,
    output logic        o_cmd_err,
    output logic        o_rx_drop
);

    localparam logic [7:0] STATUS_OK  = 8'hA5;
    localparam logic [7:0] STATUS_TMO = 8'hEE;

    typedef enum logic [2:0] {
        S_CMD    = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_SETUP  = 3'd3,
        S_ACCESS = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [3:0]  strb_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        tx_vld_q;
    logic [7:0]  tx_data_q;
    logic        cmd_err_q;
    logic        rx_drop_q;

    logic        cmd_legal;
    logic        tmo_hit;
    logic        acc_done;
    logic        tx_hs;
    logic        last_byte;
    logic [7:0]  next_byte;

    assign cmd_legal = (i_rx_data[6:4] == 3'b000);
    assign tx_hs     = tx_vld_q & i_tx_rdy;
    // Writes answer with the status byte only; reads add four data bytes.
    assign last_byte = we_q | (cnt_q == 3'd4);
    assign acc_done  = i_uart_p_rdy | tmo_hit;

`ifdef IPSL_EXPD_CMD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            tmo_q <= '0;
        end else if (state_q != S_ACCESS) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_LAST) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // rdy on the final allowed cycle still completes normally.
    assign tmo_hit = (state_q == S_ACCESS) && !i_uart_p_rdy && (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            state_q <= S_CMD;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CMD:    if (i_rx_vld && cmd_legal) state_d = S_ADDR;
            S_ADDR:   if (i_rx_vld && cnt_q == 3'd1) state_d = we_q ? S_WDATA : S_SETUP;
            S_WDATA:  if (i_rx_vld && cnt_q == 3'd3) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (acc_done) state_d = S_RESP;
            S_RESP:   if (tx_hs && last_byte) state_d = S_CMD;
            default:  state_d = S_CMD;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end else if (((state_q == S_ADDR || state_q == S_WDATA) && i_rx_vld) ||
                     (state_q == S_RESP && tx_hs)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_comb begin
        o_uart_p_sel = (state_q == S_SETUP) || (state_q == S_ACCESS);
        o_uart_p_ce  = (state_q == S_ACCESS);
        o_busy       = (state_q != S_CMD);
    end

    // cnt_q is the index of the byte currently on o_tx_data.
    always_comb begin
        case (cnt_q)
            3'd0:    next_byte = rdata_q[31:24];
            3'd1:    next_byte = rdata_q[23:16];
            3'd2:    next_byte = rdata_q[15:8];
            default: next_byte = rdata_q[7:0];
        endcase
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            we_q      <= 1'b0;
            strb_q    <= 4'd0;
            addr_q    <= 16'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= 8'd0;
            cmd_err_q <= 1'b0;
            rx_drop_q <= 1'b0;
        end else begin
            cmd_err_q <= (state_q == S_CMD) && i_rx_vld && !cmd_legal;
            rx_drop_q <= i_rx_vld && ((state_q == S_SETUP) || (state_q == S_ACCESS) ||
                                      (state_q == S_RESP));

            if (state_q == S_CMD && i_rx_vld && cmd_legal) begin
                we_q   <= i_rx_data[7];
                strb_q <= i_rx_data[3:0];
            end
            if (state_q == S_ADDR && i_rx_vld) begin
                addr_q <= {addr_q[7:0], i_rx_data};
            end
            if (state_q == S_WDATA && i_rx_vld) begin
                wdata_q <= {wdata_q[23:0], i_rx_data};
            end

            if (state_q == S_ACCESS && acc_done) begin
                rdata_q   <= i_uart_p_rdy ? i_uart_p_rdata : 32'd0;
                tx_vld_q  <= 1'b1;
                tx_data_q <= i_uart_p_rdy ? STATUS_OK : STATUS_TMO;
            end else if (state_q == S_RESP && tx_hs) begin
                if (last_byte) begin
                    tx_vld_q <= 1'b0;
                end else begin
                    tx_data_q <= next_byte;
                end
            end
        end
    end

    assign o_tx_vld       = tx_vld_q;
    assign o_tx_data      = tx_data_q;
    assign o_uart_p_strb  = strb_q;
    assign o_uart_p_addr  = addr_q;
    assign o_uart_p_wdata = wdata_q;
    assign o_uart_p_we    = we_q;
    assign o_cmd_err      = cmd_err_q;
    assign o_rx_drop      = rx_drop_q;

endmodule
